// File: rtl/rv_pkg.sv
// Shared RV32IM decode constants and the divider state encoding.
package rv_pkg;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;
endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider, one quotient bit per cycle; special cases jump straight to FIN.
module alu_divider
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy_i,
  input  logic                 rollback_i,
  input  logic                 start_i,
  input  logic                 ack_i,
  input  logic                 signed_i,
  input  logic                 rem_i,
  input  logic [XLEN-1:0]      dividend_i,
  input  logic [XLEN-1:0]      divisor_i,
  input  logic [ROB_POS_W-1:0] tag_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [XLEN-1:0]      res_o,
  output logic [ROB_POS_W-1:0] tag_o
);
  localparam int CW = $clog2(XLEN + 1);

  div_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic                qneg_q, qneg_d, rneg_q, rneg_d, remop_q, remop_d;
  logic [ROB_POS_W-1:0] tag_q, tag_d;

  logic            a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted, diff;

  assign a_neg   = signed_i & dividend_i[XLEN-1];
  assign b_neg   = signed_i & divisor_i[XLEN-1];
  assign a_mag   = a_neg ? -dividend_i : dividend_i;
  assign b_mag   = b_neg ? -divisor_i : divisor_i;
  assign div0    = (divisor_i == '0);
  assign ovf     = signed_i && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (&divisor_i);
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    remop_d = remop_q;
    tag_d   = tag_q;
    case (state_q)
      DIV_IDLE: if (start_i) begin
        tag_d   = tag_i;
        remop_d = rem_i;
        qneg_d  = 1'b0;
        rneg_d  = 1'b0;
        state_d = DIV_FIN;
        // Special results are stored pre-signed so FIN applies no correction.
        if (div0) begin
          quo_d = '1;
          rem_d = dividend_i;
        end else if (ovf) begin
          quo_d = dividend_i;
          rem_d = '0;
        end else begin
          quo_d   = a_mag;
          rem_d   = '0;
          dsr_d   = b_mag;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          cnt_d   = CW'(XLEN);
          state_d = DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DIV_FIN;
      end
      DIV_FIN: if (ack_i) state_d = DIV_IDLE;
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      remop_q <= 1'b0;
      tag_q   <= '0;
    end else if (rdy_i) begin
      if (rollback_i) begin
        state_q <= DIV_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        quo_q   <= quo_d;
        rem_q   <= rem_d;
        dsr_q   <= dsr_d;
        qneg_q  <= qneg_d;
        rneg_q  <= rneg_d;
        remop_q <= remop_d;
        tag_q   <= tag_d;
      end
    end
  end

  assign busy_o = (state_q != DIV_IDLE);
  assign done_o = (state_q == DIV_FIN);
  assign tag_o  = tag_q;
  assign res_o  = remop_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);
endmodule

// File: rtl/alu_muldiv.sv
// RV32IM execution unit: fixed-latency base/multiply pipeline plus iterative divider, one broadcast port.
module alu_muldiv
  import rv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ROB_POS_W   = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_en,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [XLEN-1:0]      val1,
  input  logic [XLEN-1:0]      val2,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      pc,
  input  logic [ROB_POS_W-1:0] rob_pos,
  output logic                 alu_busy,
  output logic                 result,
  output logic [ROB_POS_W-1:0] result_rob_pos,
  output logic [XLEN-1:0]      result_val,
  output logic                 result_jump,
  output logic [XLEN-1:0]      result_pc
);
  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic [ROB_POS_W-1:0] rob_pos;
    logic [XLEN-1:0]      val;
    logic                 jump;
    logic [XLEN-1:0]      pc;
  } bcast_t;

  logic accept, is_muldiv, is_div;
  assign accept    = rdy & ~rollback & alu_en;
  assign is_muldiv = (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  assign is_div    = is_muldiv & funct3[2];

  logic [XLEN-1:0]   op2, alu_r, mul_r, pc4;
  logic [SHW-1:0]    shamt;
  logic              taken, a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  bcast_t            exec;

  always_comb begin
    op2   = (opcode == OPCODE_OP) ? val2 : imm;
    shamt = op2[SHW-1:0];
    pc4   = pc + XLEN'(4);
    case (funct3)
      FUNCT3_ADD:  alu_r = (opcode == OPCODE_OP && funct7[5]) ? val1 - op2 : val1 + op2;
      FUNCT3_SLL:  alu_r = val1 << shamt;
      FUNCT3_SLT:  alu_r = XLEN'($signed(val1) < $signed(op2));
      FUNCT3_SLTU: alu_r = XLEN'(val1 < op2);
      FUNCT3_XOR:  alu_r = val1 ^ op2;
      FUNCT3_SR:   alu_r = funct7[5] ? $unsigned($signed(val1) >>> shamt) : val1 >> shamt;
      FUNCT3_OR:   alu_r = val1 | op2;
      default:     alu_r = val1 & op2;
    endcase
    case (funct3)
      FUNCT3_BEQ:  taken = (val1 == val2);
      FUNCT3_BNE:  taken = (val1 != val2);
      FUNCT3_BLT:  taken = ($signed(val1) < $signed(val2));
      FUNCT3_BGE:  taken = ($signed(val1) >= $signed(val2));
      FUNCT3_BLTU: taken = (val1 < val2);
      FUNCT3_BGEU: taken = (val1 >= val2);
      default:     taken = 1'b0;
    endcase
    // Sign-extend both operands to 2*XLEN so one unsigned multiply covers all variants.
    a_sgn = (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU);
    b_sgn = (funct3 == FUNCT3_MULH);
    a_ext = {{XLEN{a_sgn & val1[XLEN-1]}}, val1};
    b_ext = {{XLEN{b_sgn & val2[XLEN-1]}}, val2};
    prod  = a_ext * b_ext;
    mul_r = (funct3 == FUNCT3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    exec         = '0;
    exec.rob_pos = rob_pos;
    case (opcode)
      OPCODE_LUI:   exec.val = imm;
      OPCODE_AUIPC: exec.val = pc + imm;
      OPCODE_JAL: begin
        exec.val  = pc4;
        exec.jump = 1'b1;
        exec.pc   = pc + imm;
      end
      OPCODE_JALR: begin
        exec.val  = pc4;
        exec.jump = 1'b1;
        exec.pc   = (val1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
      end
      OPCODE_BRANCH: begin
        exec.jump = taken;
        exec.pc   = taken ? pc + imm : pc4;
      end
      OPCODE_OPIMM: exec.val = alu_r;
      OPCODE_OP:    exec.val = is_muldiv ? mul_r : alu_r;
      default:      exec.val = '0;
    endcase
  end

  logic [PIPE_STAGES-1:0] vld_q;
  bcast_t [PIPE_STAGES-1:0] pipe_q;
  logic pipe_out_vld;
  assign pipe_out_vld = vld_q[PIPE_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      pipe_q <= '0;
    end else if (rdy) begin
      if (rollback) begin
        vld_q <= '0;
      end else begin
        vld_q[0]  <= accept & ~is_div;
        pipe_q[0] <= exec;
        for (int i = 1; i < PIPE_STAGES; i++) begin
          vld_q[i]  <= vld_q[i-1];
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end
  end

  logic                 div_done, div_ack;
  logic [XLEN-1:0]      div_res;
  logic [ROB_POS_W-1:0] div_tag;
  // Pipeline has output priority; the divider holds in FIN until the port is free.
  assign div_ack = div_done & ~pipe_out_vld;

  alu_divider #(.XLEN(XLEN), .ROB_POS_W(ROB_POS_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .rdy_i      (rdy),
    .rollback_i (rollback),
    .start_i    (accept & is_div),
    .ack_i      (div_ack),
    .signed_i   (~funct3[0]),
    .rem_i      (funct3[1]),
    .dividend_i (val1),
    .divisor_i  (val2),
    .tag_i      (rob_pos),
    .busy_o     (alu_busy),
    .done_o     (div_done),
    .res_o      (div_res),
    .tag_o      (div_tag)
  );

  logic   res_q, res_d;
  bcast_t out_q, out_d;

  always_comb begin
    res_d = 1'b0;
    out_d = '0;
    if (!rollback) begin
      if (pipe_out_vld) begin
        res_d = 1'b1;
        out_d = pipe_q[PIPE_STAGES-1];
      end else if (div_done) begin
        res_d         = 1'b1;
        out_d.rob_pos = div_tag;
        out_d.val     = div_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= 1'b0;
      out_q <= '0;
    end else if (rdy) begin
      res_q <= res_d;
      out_q <= out_d;
    end
  end

  assign result         = res_q;
  assign result_rob_pos = out_q.rob_pos;
  assign result_val     = out_q.val;
  assign result_jump    = out_q.jump;
  assign result_pc      = out_q.pc;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: every expected broadcast carries its value and the cycle it must appear in.
module tb_alu_muldiv;
  localparam int P = 2;
  localparam logic [6:0] OP = 7'h33, OPI = 7'h13, BR = 7'h63, JAL = 7'h6F, JALR = 7'h67,
                         LUI = 7'h37, AUIPC = 7'h17, MD = 7'h01;

  logic        clk = 0, rst = 1, rdy = 1, rollback = 0, alu_en = 0;
  logic [6:0]  opcode = 0, funct7 = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] val1 = 0, val2 = 0, imm = 0, pc = 0;
  logic [3:0]  rob_pos = 0;
  logic        alu_busy, result, result_jump;
  logic [3:0]  result_rob_pos;
  logic [31:0] result_val, result_pc;

  alu_muldiv #(.XLEN(32), .ROB_POS_W(4), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .val1(val1), .val2(val2),
    .imm(imm), .pc(pc), .rob_pos(rob_pos), .alu_busy(alu_busy), .result(result),
    .result_rob_pos(result_rob_pos), .result_val(result_val),
    .result_jump(result_jump), .result_pc(result_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
    logic        jump;
    logic [31:0] pc;
    logic        chk_pc;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, errors = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && result) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bcast cyc=%0d tag=%0d val=%h", cyc, result_rob_pos, result_val);
      end else begin
        e = sb.pop_front();
        if (result_rob_pos !== e.tag || result_val !== e.val || result_jump !== e.jump ||
            (e.chk_pc && result_pc !== e.pc) || cyc != e.cyc) begin
          errors++;
          $display("FAIL bcast tag=%0d got val=%h jump=%b pc=%h cyc=%0d, want tag=%0d val=%h jump=%b pc=%h cyc=%0d",
                   result_rob_pos, result_val, result_jump, result_pc, cyc,
                   e.tag, e.val, e.jump, e.pc, e.cyc);
        end
      end
    end
  end

  // lat < 0: op is expected to be dropped, no broadcast pushed.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] p, input logic [3:0] tag, input logic [31:0] ev,
                       input logic ej, input logic [31:0] epc, input logic cpc, input int lat);
    exp_t e;
    opcode = op; funct3 = f3; funct7 = f7; val1 = a; val2 = b; imm = im; pc = p;
    rob_pos = tag; alu_en = 1;
    @(posedge clk); #1;
    alu_en = 0;
    if (lat >= 0) begin
      e.tag = tag; e.val = ev; e.jump = ej; e.pc = epc; e.chk_pc = cpc; e.cyc = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (alu_busy && n < 100) begin @(posedge clk); #1; n++; end
    vectors++;
    if (alu_busy) begin errors++; $display("FAIL wait_idle busy=%b want 0", alu_busy); end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL drain pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (result !== 1'b0 || alu_busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl result=%b busy=%b want 0 0", result, alu_busy);
    end
    vectors++;
    if (result_val !== 32'h0 || result_pc !== 32'h0 || result_jump !== 1'b0 || result_rob_pos !== 4'h0) begin
      errors++; $display("FAIL reset_data val=%h pc=%h jump=%b tag=%0d want all 0",
                         result_val, result_pc, result_jump, result_rob_pos);
    end
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    issue(OPI, 3'b000, 7'h00, 32'd5, 32'd0, 32'hFFFFFFFD, 32'h0, 4'd7, 32'd2, 1'b0, 32'h0, 1'b0, P);
    repeat (P) begin @(posedge clk); #1; end
    vectors++;
    if (result !== 1'b1 || result_val !== 32'd2 || result_rob_pos !== 4'd7) begin
      errors++; $display("FAIL addi_timing result=%b val=%h tag=%0d want 1 2 7", result, result_val, result_rob_pos);
    end
    @(posedge clk); #1;
    vectors++;
    if (result !== 1'b0) begin errors++; $display("FAIL addi_pulse result=%b want 0", result); end
    drain();
  endtask

  task automatic test_alu_mix();
    logic [31:0] a, b, ev;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int k;
    issue(OP,  3'b000, 7'h20, 32'd5, 32'd7, 32'h0, 32'h0, 4'd1, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b0, P);
    issue(OPI, 3'b101, 7'h20, 32'h80000000, 32'h0, 32'd4, 32'h0, 4'd2, 32'hF8000000, 1'b0, 32'h0, 1'b0, P);
    issue(OPI, 3'b101, 7'h00, 32'h80000000, 32'h0, 32'd4, 32'h0, 4'd3, 32'h08000000, 1'b0, 32'h0, 1'b0, P);
    issue(OP,  3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 4'd4, 32'd1, 1'b0, 32'h0, 1'b0, P);
    issue(OP,  3'b001, 7'h00, 32'd1, 32'd35, 32'h0, 32'h0, 4'd5, 32'd8, 1'b0, 32'h0, 1'b0, P);
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; k = $urandom_range(0, 3);
      case (k)
        0: begin f3 = 3'b000; f7 = 7'h00; ev = a + b; end
        1: begin f3 = 3'b000; f7 = 7'h20; ev = a - b; end
        2: begin f3 = 3'b100; f7 = 7'h00; ev = a ^ b; end
        default: begin f3 = 3'b011; f7 = 7'h00; ev = (a < b) ? 32'd1 : 32'd0; end
      endcase
      issue(OP, f3, f7, a, b, 32'h0, 32'h0, 4'(i), ev, 1'b0, 32'h0, 1'b0, P);
    end
    drain();
  endtask

  task automatic test_mul_back_to_back();
    issue(OP, 3'b000, MD, 32'h7FFFFFFF, 32'd2, 32'h0, 32'h0, 4'd1, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b0, P);
    issue(OP, 3'b001, MD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd2, 32'h0, 1'b0, 32'h0, 1'b0, P);
    issue(OP, 3'b011, MD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd3, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b0, P);
    issue(OP, 3'b010, MD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd4, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, P);
    drain();
  endtask

  task automatic test_div();
    int busy_cnt = 0;
    issue(OP, 3'b100, MD, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 4'd8, 32'hFFFFFFFD, 1'b0, 32'h0, 1'b0, 33);
    for (int i = 0; i < 40; i++) begin
      if (alu_busy) busy_cnt++;
      @(posedge clk); #1;
    end
    vectors++;
    if (busy_cnt != 33) begin errors++; $display("FAIL div_busy_cycles got=%0d want 33", busy_cnt); end
    issue(OP, 3'b110, MD, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 4'd9, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 33);
    wait_idle();
    issue(OP, 3'b101, MD, 32'hFFFFFFFF, 32'd3, 32'h0, 32'h0, 4'd10, 32'h55555555, 1'b0, 32'h0, 1'b0, 33);
    wait_idle();
    issue(OP, 3'b111, MD, 32'd100, 32'd7, 32'h0, 32'h0, 4'd11, 32'd2, 1'b0, 32'h0, 1'b0, 33);
    wait_idle();
    drain();
  endtask

  task automatic test_div_special();
    issue(OP, 3'b101, MD, 32'd9, 32'd0, 32'h0, 32'h0, 4'd1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1);
    wait_idle();
    issue(OP, 3'b110, MD, 32'd5, 32'd0, 32'h0, 32'h0, 4'd2, 32'd5, 1'b0, 32'h0, 1'b0, 1);
    wait_idle();
    issue(OP, 3'b100, MD, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd3, 32'h80000000, 1'b0, 32'h0, 1'b0, 1);
    wait_idle();
    issue(OP, 3'b110, MD, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd4, 32'h0, 1'b0, 32'h0, 1'b0, 1);
    wait_idle();
    drain();
    // MUL one cycle ahead of a divide-by-zero: the pipeline takes the port, divide follows.
    issue(OP, 3'b000, MD, 32'd3, 32'd4, 32'h0, 32'h0, 4'd5, 32'd12, 1'b0, 32'h0, 1'b0, P);
    issue(OP, 3'b100, MD, 32'd5, 32'd0, 32'h0, 32'h0, 4'd6, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 2);
    wait_idle();
    drain();
  endtask

  task automatic test_branch_jump();
    issue(BR, 3'b000, 7'h00, 32'd5, 32'd5, 32'h20, 32'h100, 4'd1, 32'h0, 1'b1, 32'h120, 1'b1, P);
    issue(BR, 3'b001, 7'h00, 32'd5, 32'd5, 32'h20, 32'h100, 4'd2, 32'h0, 1'b0, 32'h104, 1'b1, P);
    issue(BR, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h200, 4'd3, 32'h0, 1'b1, 32'h240, 1'b1, P);
    issue(BR, 3'b111, 7'h00, 32'd1, 32'hFFFFFFFF, 32'h40, 32'h200, 4'd4, 32'h0, 1'b0, 32'h204, 1'b1, P);
    issue(JALR, 3'b000, 7'h00, 32'h203, 32'h0, 32'd4, 32'h300, 4'd5, 32'h304, 1'b1, 32'h206, 1'b1, P);
    issue(JAL, 3'b000, 7'h00, 32'h0, 32'h0, 32'hFFFFFFF8, 32'h400, 4'd6, 32'h404, 1'b1, 32'h3F8, 1'b1, P);
    issue(LUI, 3'b000, 7'h00, 32'h0, 32'h0, 32'h12345000, 32'h0, 4'd7, 32'h12345000, 1'b0, 32'h0, 1'b0, P);
    issue(AUIPC, 3'b000, 7'h00, 32'h0, 32'h0, 32'h2000, 32'h1000, 4'd8, 32'h3000, 1'b0, 32'h0, 1'b0, P);
    issue(7'h00, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 32'h500, 4'd9, 32'h0, 1'b0, 32'h0, 1'b0, P);
    drain();
  endtask

  task automatic test_rollback();
    int seen = 0;
    issue(OP, 3'b100, MD, 32'd100, 32'd3, 32'h0, 32'h0, 4'd1, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    repeat (9) begin @(posedge clk); #1; end
    rollback = 1;
    @(posedge clk); #1;
    rollback = 0;
    vectors++;
    if (alu_busy !== 1'b0 || result !== 1'b0) begin
      errors++; $display("FAIL rollback_div busy=%b result=%b want 0 0", alu_busy, result);
    end
    issue(OPI, 3'b000, 7'h00, 32'd1, 32'd0, 32'd1, 32'h0, 4'd2, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    rollback = 1; alu_en = 1;
    @(posedge clk); #1;
    rollback = 0; alu_en = 0;
    for (int i = 0; i < 40; i++) begin
      if (result) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen != 0) begin errors++; $display("FAIL rollback_flush bcasts=%0d want 0", seen); end
  endtask

  task automatic test_freeze();
    int seen = 0;
    issue(OPI, 3'b000, 7'h00, 32'd10, 32'd0, 32'd1, 32'h0, 4'd3, 32'd11, 1'b0, 32'h0, 1'b0, P + 3);
    rdy = 0;
    opcode = OPI; funct3 = 3'b000; val1 = 32'd77; imm = 32'd1; rob_pos = 4'd9; alu_en = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (result) seen++;
    end
    rdy = 1; alu_en = 0;
    vectors++;
    if (seen != 0) begin errors++; $display("FAIL freeze_hold bcasts=%0d want 0", seen); end
    drain();
  endtask

  task automatic test_rst_mid();
    int seen = 0;
    issue(OPI, 3'b000, 7'h00, 32'd1, 32'd0, 32'd1, 32'h0, 4'd1, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    issue(OPI, 3'b000, 7'h00, 32'd2, 32'd0, 32'd1, 32'h0, 4'd2, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    @(posedge clk); #1;
    vectors++;
    if (result !== 1'b1 || result_val !== 32'd2) begin
      errors++; $display("FAIL rst_pre result=%b val=%h want 1 00000002", result, result_val);
    end
    #1 rst = 1;
    #1;
    vectors++;
    if (result !== 1'b0 || result_val !== 32'h0 || alu_busy !== 1'b0) begin
      errors++; $display("FAIL rst_async result=%b val=%h busy=%b want 0 0 0", result, result_val, alu_busy);
    end
    @(posedge clk); #1; rst = 0;
    for (int i = 0; i < 6; i++) begin
      if (result) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen != 0) begin errors++; $display("FAIL rst_flush bcasts=%0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu_mix();
    test_mul_back_to_back();
    test_div();
    test_div_special();
    test_branch_jump();
    test_rollback();
    test_freeze();
    test_rst_mid();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
